// File: rtl/state_enabler.sv
// Per-channel state/sub-state match enables with level or pulse mode,
// shared hold timeout and sticky per-channel timeout flags.
module state_enabler #(
    parameter int ST_W  = 2,
    parameter int STL_W = 3,
    parameter int NCH   = 2,
    parameter int TO_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ST_W-1:0]             ST,
    input  logic [STL_W-1:0]            ST_L,
    input  logic [NCH*ST_W-1:0]         match_st,
    input  logic [NCH*(2**STL_W)-1:0]   match_mask,
    input  logic [NCH-1:0]              mode,
    input  logic [TO_W-1:0]             timeout,
    input  logic [NCH-1:0]              clr,
    output logic [NCH-1:0]              en,
    output logic [NCH-1:0]              to_flag,
    output logic                        any_en
);

    localparam int NSL = 2**STL_W;
    localparam logic [TO_W-1:0] INC  = 1;
    localparam logic [TO_W:0]   INCW = 1;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [TO_W-1:0] cnt_q, cnt_d;
        logic            cond_q;
        logic            en_q, en_d;
        logic            flag_q, flag_d;
        logic [NSL-1:0]  mask;
        logic            cond;
        logic            live;
        logic            set;

        assign mask = match_mask[g*NSL +: NSL];

        always_comb begin
            cond  = (ST == match_st[g*ST_W +: ST_W]) && mask[ST_L];
            cnt_d = '0;
            if (cond) begin
                // Saturate so an all-ones timeout can never be exceeded
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + INC;
            end
            live   = (timeout == '0) || (cnt_d <= timeout);
            en_d   = cond && live && (!mode[g] || !cond_q);
            set    = cond && (timeout != '0) &&
                     ({1'b0, cnt_d} == ({1'b0, timeout} + INCW));
            flag_d = set || (flag_q && !clr[g]);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                cond_q <= 1'b0;
                en_q   <= 1'b0;
                flag_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                cond_q <= cond;
                en_q   <= en_d;
                flag_q <= flag_d;
            end
        end

        assign en[g]      = en_q;
        assign to_flag[g] = flag_q;
    end

    assign any_en = |en;

endmodule

// File: tb/tb_state_enabler.sv
// Self-checking bench for state_enabler: directed table, corner
// sequences and randomized traffic against a run-length model.
module tb_state_enabler;

    localparam int ST_W  = 2;
    localparam int STL_W = 3;
    localparam int NCH   = 2;
    localparam int TO_W  = 8;
    localparam int NSL   = 8;
    localparam int MAXC  = 255;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [ST_W-1:0]           ST;
    logic [STL_W-1:0]          ST_L;
    logic [NCH*ST_W-1:0]       match_st;
    logic [NCH*NSL-1:0]        match_mask;
    logic [NCH-1:0]            mode;
    logic [TO_W-1:0]           timeout;
    logic [NCH-1:0]            clr;
    logic [NCH-1:0]            en;
    logic [NCH-1:0]            to_flag;
    logic                      any_en;

    state_enabler #(
        .ST_W(ST_W), .STL_W(STL_W), .NCH(NCH), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst), .ST(ST), .ST_L(ST_L),
        .match_st(match_st), .match_mask(match_mask),
        .mode(mode), .timeout(timeout), .clr(clr),
        .en(en), .to_flag(to_flag), .any_en(any_en)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference: length of the current run of true cond per channel
    int             run [NCH];
    logic [NCH-1:0] m_en   = '0;
    logic [NCH-1:0] m_flag = '0;

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < NCH; i++) run[i] = 0;
            m_en   = '0;
            m_flag = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                logic c;
                int   s;
                logic live;
                logic set;
                c = (ST == match_st[i*ST_W +: ST_W]) &&
                    match_mask[i*NSL + int'(ST_L)];
                run[i] = c ? run[i] + 1 : 0;
                s      = (run[i] > MAXC) ? MAXC : run[i];
                live   = (timeout == 0) || (s <= int'(timeout));
                m_en[i] = c && live && (!mode[i] || run[i] == 1);
                set    = c && (timeout != 0) && (s == int'(timeout) + 1);
                if (set) m_flag[i] = 1'b1;
                else if (clr[i]) m_flag[i] = 1'b0;
            end
        end
    endtask

    task automatic check(string name, logic [4:0] act, logic [4:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0t: {any,flag,en} got %b expected %b",
                     name, $time, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(string name);
        model_edge();
        @(posedge clk);
        #1;
        check(name, {any_en, to_flag, en}, {|m_en, m_flag, m_en});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = '0;
        step("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        logic       r;
        logic [1:0] st;
        logic [2:0] stl;
        logic [7:0] to;
        logic [1:0] cl;
        logic [1:0] md;
        logic [1:0] xen;
        logic [1:0] xfl;
    } vec_t;

    vec_t tbl[$];

    int hi;
    int pulses;
    int first_p;
    int second_p;

    initial begin
        rst        = 1'b1;
        ST         = '0;
        ST_L       = '0;
        match_st   = {2'd0, 2'd2};
        match_mask = {8'h00, 8'b0000_0110};
        mode       = '0;
        timeout    = '0;
        clr        = '0;

        //                 r   st    stl   to    clr    mode   en     flag
        tbl.push_back(vec_t'{1'b1, 2'd0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd0, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd0, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd0, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd3, 8'd0, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd2, 8'd3, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd2, 8'd3, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd2, 8'd3, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd2, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd2, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01});
        tbl.push_back(vec_t'{1'b0, 2'd1, 3'd2, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01});
        tbl.push_back(vec_t'{1'b0, 2'd1, 3'd2, 8'd3, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd3, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd3, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd3, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd3, 2'b01, 2'b00, 2'b00, 2'b01});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd3, 2'b00, 2'b00, 2'b00, 2'b01});
        tbl.push_back(vec_t'{1'b1, 2'd2, 3'd1, 8'd3, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd3, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back(vec_t'{1'b0, 2'd2, 3'd1, 8'd3, 2'b00, 2'b00, 2'b01, 2'b00});

        for (int i = 0; i < tbl.size(); i++) begin
            rst     = tbl[i].r;
            ST      = tbl[i].st;
            ST_L    = tbl[i].stl;
            timeout = tbl[i].to;
            clr     = tbl[i].cl;
            mode    = tbl[i].md;
            step("tbl_model");
            check($sformatf("tbl_row%0d", i), {any_en, to_flag, en},
                  {|tbl[i].xen, tbl[i].xfl, tbl[i].xen});
        end

        // Pulse mode, T=2: hold 5, drop 1, hold 5
        do_reset();
        mode = 2'b01; timeout = 8'd2; ST_L = 3'd1;
        pulses = 0; first_p = -1; second_p = -1;
        for (int c = 0; c < 11; c++) begin
            ST = (c == 5) ? 2'd0 : 2'd2;
            step("pulse_seq");
            if (en[0]) begin
                pulses++;
                if (first_p < 0) first_p = c;
                else second_p = c;
            end
            if (c == 2) check_int("pulse_flag_3rd", int'(to_flag[0]), 1);
            if (c == 1) check_int("pulse_flag_2nd", int'(to_flag[0]), 0);
        end
        check_int("pulse_count", pulses, 2);
        check_int("pulse_gap", second_p - first_p, 6);

        // Pulse mode, cond toggling every cycle
        do_reset();
        timeout = 8'd0; pulses = 0;
        for (int c = 0; c < 10; c++) begin
            ST = c[0] ? 2'd0 : 2'd2;
            step("toggle_seq");
            if (en[0]) pulses++;
        end
        check_int("toggle_pulses", pulses, 5);

        // T=1 level
        do_reset();
        mode = 2'b00; timeout = 8'd1; ST = 2'd2; hi = 0;
        for (int c = 0; c < 4; c++) begin
            step("t1_seq");
            if (en[0]) hi++;
            if (c == 1) check_int("t1_flag", int'(to_flag[0]), 1);
        end
        check_int("t1_en_cycles", hi, 1);

        // All-ones timeout behaves as no timeout
        do_reset();
        timeout = 8'd255; hi = 0;
        for (int c = 0; c < 300; c++) begin
            step("sat255_seq");
            if (en[0]) hi++;
        end
        check_int("sat255_en_cycles", hi, 300);
        check_int("sat255_flag", int'(to_flag[0]), 0);

        // Largest effective timeout, held past counter saturation
        do_reset();
        timeout = 8'd254; hi = 0;
        for (int c = 0; c < 300; c++) begin
            step("sat254_seq");
            if (en[0]) hi++;
        end
        check_int("sat254_en_cycles", hi, 254);
        check_int("sat254_flag", int'(to_flag[0]), 1);

        // Randomized traffic
        do_reset();
        match_st = {2'd2, 2'd2};
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                match_mask = {8'($urandom), 8'($urandom)};
                match_st   = {2'($urandom), 2'($urandom)};
            end
            if ($urandom_range(0, 99) < 5) begin
                case ($urandom_range(0, 5))
                    0: timeout = 8'd0;
                    1: timeout = 8'd1;
                    2: timeout = 8'd2;
                    3: timeout = 8'd5;
                    4: timeout = 8'd255;
                    default: timeout = 8'($urandom_range(0, 20));
                endcase
            end
            if ($urandom_range(0, 99) < 20) ST = 2'($urandom);
            if ($urandom_range(0, 99) < 15) ST_L = 3'($urandom);
            if ($urandom_range(0, 99) < 5) mode = 2'($urandom);
            clr = ($urandom_range(0, 99) < 8) ? 2'($urandom) : 2'b00;
            rst = ($urandom_range(0, 999) < 5);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
